// File: rtl/master_request_arbiter.sv
// Round-robin arbiter sharing one SAP master request port among C_NUM_REQ
// requesters. Each issued request is tagged, and its owner is queued so that
// in-order completions are routed back to the requester that issued them.
module master_request_arbiter #(
  parameter int unsigned C_NUM_REQ         = 4,
  parameter int unsigned C_MAX_OUTSTANDING = 8
) (
  input  logic                      master_clk,
  input  logic                      master_rst,
  input  logic [C_NUM_REQ-1:0]      req_valid,
  input  logic [4*C_NUM_REQ-1:0]    req_type,
  input  logic [10*C_NUM_REQ-1:0]   req_flow,
  input  logic [64*C_NUM_REQ-1:0]   req_address,
  input  logic [36*C_NUM_REQ-1:0]   req_length,
  output logic [C_NUM_REQ-1:0]      req_accept,
  output logic [3:0]                req_issue_tag,
  output logic [C_NUM_REQ-1:0]      req_done,
  output logic [6:0]                req_done_error,
  output logic                      master_request,
  input  logic                      master_request_ack,
  input  logic                      master_request_complete,
  input  logic [6:0]                master_request_error,
  output logic [3:0]                master_request_tag,
  output logic [3:0]                master_request_type,
  output logic [9:0]                master_request_flow,
  output logic [63:0]               master_request_local_address,
  output logic [35:0]               master_request_length,
  output logic [4:0]                outstanding_count,
  output logic                      spurious_complete
);

  localparam int unsigned W_IDX = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int unsigned W_PTR = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
  localparam logic [W_IDX-1:0] C_LAST_IDX = W_IDX'(C_NUM_REQ - 1);
  localparam logic [W_PTR-1:0] C_LAST_PTR = W_PTR'(C_MAX_OUTSTANDING - 1);
  localparam logic [4:0]       C_MAX_CNT  = 5'(C_MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t             r_state;
  logic [W_IDX-1:0]   r_rr_ptr;
  logic [W_IDX-1:0]   r_winner;
  logic [3:0]         r_tag_ctr;
  logic [W_IDX-1:0]   r_fifo [C_MAX_OUTSTANDING];
  logic [W_PTR-1:0]   r_wr_ptr;
  logic [W_PTR-1:0]   r_rd_ptr;
  logic [4:0]         r_count;

  logic               w_found;
  logic [W_IDX-1:0]   w_sel_idx;
  logic [W_IDX-1:0]   w_cand;
  logic               w_push;
  logic               w_pop;

  assign w_push            = (r_state == S_ISSUE) && master_request_ack;
  assign w_pop             = master_request_complete && (r_count != '0);
  assign outstanding_count = r_count;

  // Pick the first pending requester at or after the round-robin pointer.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int unsigned off = 0; off < C_NUM_REQ; off++) begin
      w_cand = W_IDX'((32'(r_rr_ptr) + off) % C_NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  // Request FSM: latch winner fields in IDLE, hold the strobe in ISSUE until ack.
  always_ff @(posedge master_clk or negedge master_rst) begin
    if (!master_rst) begin
      r_state                      <= S_IDLE;
      r_rr_ptr                     <= '0;
      r_winner                     <= '0;
      r_tag_ctr                    <= '0;
      req_accept                   <= '0;
      req_issue_tag                <= '0;
      master_request               <= 1'b0;
      master_request_tag           <= '0;
      master_request_type          <= '0;
      master_request_flow          <= '0;
      master_request_local_address <= '0;
      master_request_length        <= '0;
    end else begin
      req_accept <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found && (r_count < C_MAX_CNT)) begin
            r_winner                     <= w_sel_idx;
            master_request               <= 1'b1;
            master_request_tag           <= r_tag_ctr;
            master_request_type          <= req_type[32'(w_sel_idx)*4 +: 4];
            master_request_flow          <= req_flow[32'(w_sel_idx)*10 +: 10];
            master_request_local_address <= req_address[32'(w_sel_idx)*64 +: 64];
            master_request_length        <= req_length[32'(w_sel_idx)*36 +: 36];
            r_state                      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (master_request_ack) begin
            master_request       <= 1'b0;
            req_accept[r_winner] <= 1'b1;
            req_issue_tag        <= r_tag_ctr;
            r_tag_ctr            <= r_tag_ctr + 4'd1;
            r_rr_ptr             <= (r_winner == C_LAST_IDX) ? '0 : r_winner + 1'b1;
            r_state              <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Owner storage; contents need no reset since occupancy is tracked by r_count.
  always_ff @(posedge master_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_winner;
  end

  // Owner FIFO pointers, occupancy, completion routing and spurious flag.
  always_ff @(posedge master_clk or negedge master_rst) begin
    if (!master_rst) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      req_done          <= '0;
      req_done_error    <= '0;
      spurious_complete <= 1'b0;
    end else begin
      req_done <= '0;
      if (w_push) r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (master_request_complete) begin
        if (w_pop) begin
          req_done[r_fifo[r_rd_ptr]] <= 1'b1;
          req_done_error             <= master_request_error;
          r_rd_ptr                   <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        end else begin
          spurious_complete <= 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_master_request_arbiter.sv
// Scoreboard bench for master_request_arbiter: expected accepts/dones are
// queued when ack/complete are driven and matched against DUT pulses.
module tb_master_request_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [4*N-1:0]    req_type;
  logic [10*N-1:0]   req_flow;
  logic [64*N-1:0]   req_address;
  logic [36*N-1:0]   req_length;
  logic [N-1:0]      req_accept;
  logic [3:0]        req_issue_tag;
  logic [N-1:0]      req_done;
  logic [6:0]        req_done_error;
  logic              mr;
  logic              mr_ack = 1'b0;
  logic              mr_complete = 1'b0;
  logic [6:0]        mr_error = '0;
  logic [3:0]        mr_tag;
  logic [3:0]        mr_type;
  logic [9:0]        mr_flow;
  logic [63:0]       mr_addr;
  logic [35:0]       mr_len;
  logic [4:0]        out_cnt;
  logic              spurious;

  always #5 clk = ~clk;

  master_request_arbiter #(.C_NUM_REQ(N), .C_MAX_OUTSTANDING(8)) dut (
    .master_clk(clk), .master_rst(rst_n),
    .req_valid(req_valid), .req_type(req_type), .req_flow(req_flow),
    .req_address(req_address), .req_length(req_length),
    .req_accept(req_accept), .req_issue_tag(req_issue_tag),
    .req_done(req_done), .req_done_error(req_done_error),
    .master_request(mr), .master_request_ack(mr_ack),
    .master_request_complete(mr_complete), .master_request_error(mr_error),
    .master_request_tag(mr_tag), .master_request_type(mr_type),
    .master_request_flow(mr_flow), .master_request_local_address(mr_addr),
    .master_request_length(mr_len), .outstanding_count(out_cnt),
    .spurious_complete(spurious)
  );

  typedef struct { int idx; logic [3:0] tag; } acc_t;
  typedef struct { int idx; logic [6:0] err; } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];
  int    owner_q[$];
  logic [3:0] exp_tag;
  int    checks;
  int    passed;
  acc_t  m_a;
  done_t m_d;

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0; mr_ack = 1'b0; mr_complete = 1'b0; mr_error = '0;
    exp_acc.delete(); exp_done.delete(); owner_q.delete(); exp_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_issue(input int idx);
    bit   got;
    acc_t t;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (mr === 1'b1) begin
        mr_ack = 1'b1;
        t.idx = idx; t.tag = exp_tag;
        exp_acc.push_back(t);
        owner_q.push_back(idx);
        exp_tag = exp_tag + 4'd1;
        @(posedge clk); #1;
        mr_ack = 1'b0;
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL issue_timeout: master_request=%b, required 1 for requester %0d", mr, idx);
    end
  endtask

  task automatic do_complete(input logic [6:0] err);
    done_t d;
    mr_complete = 1'b1; mr_error = err;
    if (owner_q.size() > 0) begin
      d.idx = owner_q.pop_front(); d.err = err;
      exp_done.push_back(d);
    end
    @(posedge clk); #1;
    mr_complete = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (mr !== 1'b0 || mr_tag !== '0 || mr_type !== '0 || mr_flow !== '0 || mr_addr !== '0 || mr_len !== '0) begin
      $display("FAIL reset_request: req=%b tag=%h type=%h flow=%h addr=%h len=%h, required all 0", mr, mr_tag, mr_type, mr_flow, mr_addr, mr_len);
    end else passed++;
    checks++;
    if (req_accept !== '0 || req_done !== '0 || req_done_error !== '0 || req_issue_tag !== '0 || out_cnt !== '0 || spurious !== 1'b0) begin
      $display("FAIL reset_status: acc=%b done=%b err=%h itag=%h cnt=%0d spur=%b, required all 0", req_accept, req_done, req_done_error, req_issue_tag, out_cnt, spurious);
    end else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int   high;
    acc_t t;
    high = 0;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (mr !== 1'b1 || mr_addr !== 64'h1000 || mr_len !== 36'h40 || mr_tag !== 4'h0 || mr_type !== 4'h1) begin
      $display("FAIL single_fields: req=%b addr=%h len=%h tag=%h type=%h, required 1 1000 40 0 1", mr, mr_addr, mr_len, mr_tag, mr_type);
    end else passed++;
    for (int c = 0; c < 3; c++) begin
      if (mr === 1'b1) high++;
      if (c < 2) begin @(posedge clk); #1; end
    end
    mr_ack = 1'b1;
    t.idx = 0; t.tag = exp_tag;
    exp_acc.push_back(t); owner_q.push_back(0); exp_tag = exp_tag + 4'd1;
    @(posedge clk); #1;
    mr_ack = 1'b0; req_valid = '0;
    checks++;
    if (high != 3 || mr !== 1'b0 || out_cnt !== 5'd1) begin
      $display("FAIL single_issue: high_cycles=%0d req=%b cnt=%0d, required 3 0 1", high, mr, out_cnt);
    end else passed++;
    do_complete(7'h00);
    checks++;
    if (out_cnt !== 5'd0) $display("FAIL single_complete_count: got %0d, required 0", out_cnt);
    else passed++;
  endtask

  task automatic test_round_robin();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) do_issue(order[i]);
    req_valid = '0;
    checks++;
    if (out_cnt !== 5'd5) $display("FAIL rr_count: got %0d, required 5", out_cnt);
    else passed++;
    for (int i = 0; i < 5; i++) do_complete(7'(i));
    checks++;
    if (out_cnt !== 5'd0) $display("FAIL rr_drain_count: got %0d, required 0", out_cnt);
    else passed++;
  endtask

  task automatic test_outstanding_limit();
    bit saw;
    apply_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) do_issue(0);
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (mr === 1'b1) saw = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw || out_cnt !== 5'd8) $display("FAIL limit_block: saw_request=%b cnt=%0d, required 0 8", saw, out_cnt);
    else passed++;
    do_complete(7'h01);
    do_issue(0);
    req_valid = '0;
    checks++;
    if (out_cnt !== 5'd8) $display("FAIL limit_reissue_count: got %0d, required 8", out_cnt);
    else passed++;
    for (int i = 0; i < 8; i++) do_complete(7'h02);
    checks++;
    if (out_cnt !== 5'd0) $display("FAIL limit_drain_count: got %0d, required 0", out_cnt);
    else passed++;
  endtask

  task automatic test_completion_routing();
    apply_reset();
    req_valid = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if (mr !== 1'b1 || mr_addr !== 64'h1200 || mr_flow !== 10'h102) begin
      $display("FAIL route_fields: req=%b addr=%h flow=%h, required 1 1200 102", mr, mr_addr, mr_flow);
    end else passed++;
    do_issue(2);
    req_valid = 4'b0001; do_issue(0);
    req_valid = 4'b0010; do_issue(1);
    req_valid = '0;
    do_complete(7'h00);
    do_complete(7'h05);
    do_complete(7'h7F);
    checks++;
    if (out_cnt !== 5'd0) $display("FAIL route_count: got %0d, required 0", out_cnt);
    else passed++;
  endtask

  task automatic test_ack_and_complete();
    acc_t  t;
    done_t d;
    bit    got;
    apply_reset();
    req_valid = 4'b0001;
    do_issue(0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (mr === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    mr_ack = 1'b1; mr_complete = 1'b1; mr_error = 7'h11;
    d.idx = owner_q.pop_front(); d.err = 7'h11; exp_done.push_back(d);
    t.idx = 0; t.tag = exp_tag; exp_acc.push_back(t);
    owner_q.push_back(0); exp_tag = exp_tag + 4'd1;
    @(posedge clk); #1;
    mr_ack = 1'b0; mr_complete = 1'b0; req_valid = '0;
    checks++;
    if (!got || req_accept !== 4'b0001 || req_done !== 4'b0001 || out_cnt !== 5'd1) begin
      $display("FAIL ack_complete: got_req=%b acc=%b done=%b cnt=%0d, required 1 0001 0001 1", got, req_accept, req_done, out_cnt);
    end else passed++;
    do_complete(7'h22);
  endtask

  task automatic test_tag_wrap();
    bit got;
    apply_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      do_issue(0);
      do_complete(7'(k));
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (mr === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!got || mr_tag !== 4'h0) $display("FAIL tag_wrap: req=%b tag=%h, required 1 0", mr, mr_tag);
    else passed++;
    do_issue(0);
    req_valid = '0;
    do_complete(7'h03);
  endtask

  task automatic test_spurious();
    apply_reset();
    do_complete(7'h44);
    checks++;
    if (spurious !== 1'b1 || req_done !== '0 || out_cnt !== 5'd0) begin
      $display("FAIL spurious: spur=%b done=%b cnt=%0d, required 1 0000 0", spurious, req_done, out_cnt);
    end else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (spurious !== 1'b1) $display("FAIL spurious_sticky: got %b, required 1", spurious);
    else passed++;
  endtask

  task automatic test_reset_mid_issue();
    bit got;
    apply_reset();
    req_valid = 4'b0001;
    do_issue(0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (mr === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!got || mr !== 1'b0 || out_cnt !== 5'd0 || mr_addr !== '0 || mr_tag !== '0) begin
      $display("FAIL reset_mid_issue: got_req=%b req=%b cnt=%0d addr=%h tag=%h, required 1 0 0 0 0", got, mr, out_cnt, mr_addr, mr_tag);
    end else passed++;
    req_valid = '0;
    exp_acc.delete(); exp_done.delete(); owner_q.delete(); exp_tag = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mr !== 1'b0 || req_accept !== '0 || req_done !== '0 || spurious !== 1'b0) begin
      $display("FAIL reset_after: req=%b acc=%b done=%b spur=%b, required 0 0 0 0", mr, req_accept, req_done, spurious);
    end else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; exp_tag = '0;
    for (int i = 0; i < N; i++) begin
      req_type[i*4 +: 4]      = 4'(i + 1);
      req_flow[i*10 +: 10]    = 10'(10'h100 + i);
      req_address[i*64 +: 64] = 64'(64'h1000 + i * 64'h100);
      req_length[i*36 +: 36]  = 36'(36'h40 + i);
    end
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (req_accept !== '0) begin
            checks++;
            if (exp_acc.size() == 0) begin
              $display("FAIL accept_unexpected: acc=%b tag=%h, required no pulse", req_accept, req_issue_tag);
            end else begin
              m_a = exp_acc.pop_front();
              if (req_accept !== 4'(1 << m_a.idx) || req_issue_tag !== m_a.tag)
                $display("FAIL accept: acc=%b tag=%h, required %b %h", req_accept, req_issue_tag, 4'(1 << m_a.idx), m_a.tag);
              else passed++;
            end
          end
          if (req_done !== '0) begin
            checks++;
            if (exp_done.size() == 0) begin
              $display("FAIL done_unexpected: done=%b err=%h, required no pulse", req_done, req_done_error);
            end else begin
              m_d = exp_done.pop_front();
              if (req_done !== 4'(1 << m_d.idx) || req_done_error !== m_d.err)
                $display("FAIL done: done=%b err=%h, required %b %h", req_done, req_done_error, 4'(1 << m_d.idx), m_d.err);
              else passed++;
            end
          end
        end
      end
    join_none

    test_reset();
    test_single();
    test_round_robin();
    test_outstanding_limit();
    test_completion_routing();
    test_ack_and_complete();
    test_tag_wrap();
    test_spurious();
    test_reset_mid_issue();

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_acc.size() != 0 || exp_done.size() != 0)
      $display("FAIL scoreboard_drain: pending accepts=%0d dones=%0d, required 0 0", exp_acc.size(), exp_done.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/master_request_arbiter.md
# master_request_arbiter

Shares the single SAP master request port of `brute_force_matcher` among C_NUM_REQ internal requesters, for example a descriptor fetcher, a key loader and a result writer. The arbiter works as follows:
- Requesters are served round-robin.
- The SAP request handshake is driven on behalf of the granted requester and each issued request is tagged.
- The owner of every outstanding request is tracked, so each in-order `master_request_complete` (with its error code) is routed back to the requester that issued it.

## Interface
Parameters:
- C_NUM_REQ, 4: number of requesters (2..8).
- C_MAX_OUTSTANDING, 8: maximum issued-but-uncompleted requests (1..16); also the depth of the owner FIFO.

Ports:
- master_clk  in  1  single clock for all logic.
- master_rst  in  1  reset; asynchronous, active-low.
- req_valid  in  C_NUM_REQ  per-requester request pending; held until accepted.
- req_type  in  4*C_NUM_REQ  request type, slice i belongs to requester i.
- req_flow  in  10*C_NUM_REQ  flow field per requester.
- req_address  in  64*C_NUM_REQ  local address per requester.
- req_length  in  36*C_NUM_REQ  byte length per requester.
- req_accept  out  C_NUM_REQ  one-cycle pulse: request i issued and acknowledged.
- req_issue_tag  out  4  tag assigned to the request, valid with req_accept.
- req_done  out  C_NUM_REQ  one-cycle pulse: request of requester i completed.
- req_done_error  out  7  error code, valid with req_done.
- master_request  out  1  SAP request strobe.
- master_request_ack  in  1  SAP acceptance.
- master_request_complete  in  1  SAP completion pulse; completions arrive in issue order.
- master_request_error  in  7  completion error, valid with complete.
- master_request_tag  out  4  tag of the current request.
- master_request_type  out  4  type of the current request.
- master_request_flow  out  10  flow field of the current request.
- master_request_local_address  out  64  local address of the current request.
- master_request_length  out  36  length of the current request.
- outstanding_count  out  5  number of uncompleted requests.
- spurious_complete  out  1  sticky: a completion arrived with the owner FIFO empty.

## Operation
- State machine IDLE / ISSUE.
- IDLE:
  - If any req_valid is set and outstanding_count < C_MAX_OUTSTANDING, select the winner.
  - The winner is the first set req_valid at or after rr_ptr, wrapping modulo C_NUM_REQ.
  - Register the winner's fields into the master_request_* outputs, plus master_request_tag = tag_ctr, then go to ISSUE.
- ISSUE:
  - master_request = 1; all master_request_* fields stay stable.
  - On the cycle master_request_ack = 1:
    - Pulse req_accept[winner] with req_issue_tag = tag_ctr.
    - Push the winner index onto the owner FIFO.
    - Increment tag_ctr (wraps 15 -> 0).
    - Set rr_ptr = winner+1 mod C_NUM_REQ.
    - Return to IDLE.
- Completion, independent of state:
  - On master_request_complete = 1 with the FIFO non-empty: pop the head owner h and pulse req_done[h] with req_done_error = master_request_error.
  - With the FIFO empty: ignore the completion and set spurious_complete (cleared only by reset).
- Count rules:
  - outstanding_count = FIFO occupancy.
  - Ack alone: +1. Complete alone: -1. Ack and complete in the same cycle: unchanged, with both the push and the pop performed.
- FIFO full (count = C_MAX_OUTSTANDING): IDLE issues no new selection. An in-flight ISSUE was admitted with count < max, so it never overflows.
- A requester that drops req_valid while it is the winner in ISSUE has no effect. The request completes with the latched fields; requesters must not withdraw a request.

## Timing
- Reset values (async assert, sync deassert):
  - master_request 0, all master_request_* fields 0.
  - req_accept 0, req_done 0, req_done_error 0, req_issue_tag 0.
  - tag_ctr 0, rr_ptr 0, outstanding_count 0, spurious_complete 0, state IDLE.
- Latency:
  - req_valid rising in IDLE -> master_request = 1 on the next cycle.
  - Ack at cycle n -> req_accept at n+1 (registered) and master_request = 0 at n+1.
  - Earliest next master_request is n+2, giving a minimum of 2 cycles per request.
- Completion: master_request_complete at cycle n -> req_done at n+1; outstanding_count updates at n+1.
- master_request_ack is only sampled while master_request = 1. An ack received in IDLE is ignored.
- Reset asserted mid-ISSUE: master_request drops immediately and the FIFO contents are discarded. No req_accept or req_done is produced for the lost requests.

## Test plan
- Single requester: req_valid[0] with length 0x40 and address 0x1000. Ack at the 3rd request cycle -> master_request is high for 3 cycles with tag 0, req_accept[0] pulses once, outstanding_count = 1. A complete with error 0 -> req_done[0] and count 0.
- Round-robin: all 4 requesters valid, ack immediate on every request -> issue order 0,1,2,3,0 with tags 0..4; each req_accept pulses in that order.
- Outstanding limit: C_MAX_OUTSTANDING = 2, no completions, 3 requesters valid -> exactly 2 issues, then master_request stays 0. One complete -> the third request issues.
- Completion routing: issue order 2,0,1, then 3 completions with errors 0x00, 0x05, 0x7F -> req_done pulses on 2, 0, 1 with those errors in order.
- Simultaneous ack and complete in one cycle -> outstanding_count unchanged, both req_accept and req_done pulse. Tag wrap: 17 issues -> tag sequence wraps 15 -> 0.
- Spurious and reset:
  - A complete with an empty FIFO -> spurious_complete = 1, no req_done.
  - Reset asserted during ISSUE -> master_request = 0 immediately and all outputs return to their reset values.
